// File: rtl/obriensp_be8.sv
// obriensp_be8: 8-bit accumulator CPU that fetches every instruction byte from an I2C EEPROM.
// Latency: one random-read I2C transaction per byte (~39 bit-times); execute takes 1 cycle after the last byte.
// Backpressure: none. ACK bits from the EEPROM are ignored and SCL is never stretched.
//
// Ports:
//   clk     - system clock
//   rst_n   - synchronous reset, active HIGH (held in reset while 1)
//   ena     - tile enable, ignored
//   ui_in   - unused
//   uo_out  - output register OUTR
//   uio_in  - [3] SDA line in; all other bits unused
//   uio_out - [2] scl_o, [3] sda_o (1 = released), [4] halted; all other bits 0
//   uio_oe  - constant 8'b0001_1100
module obriensp_be8 #(
  parameter logic [6:0] I2C_DEV_ADDR = 7'h50,
  parameter int         QUARTER      = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam logic [7:0] QLAST = 8'(QUARTER - 1);
  localparam logic [7:0] DEV_W = {I2C_DEV_ADDR, 1'b0};
  localparam logic [7:0] DEV_R = {I2C_DEV_ADDR, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WBYTE,
    S_RSTART,
    S_RBYTE,
    S_STOP,
    S_EXEC,
    S_HALT
  } state_t;

  state_t     r_state;
  state_t     w_next;

  logic [7:0] r_qcnt;     // clk cycles inside the current quarter
  logic [1:0] r_q;        // quarter index inside a bit / condition
  logic [3:0] r_bit;      // bit index inside a byte, 8 = ACK/NACK slot
  logic [1:0] r_wsel;     // which byte is being written: 0 dev+W, 1 word addr, 2 dev+R
  logic [7:0] r_rx;
  logic [7:0] r_ir;
  logic [7:0] r_opnd;
  logic [7:0] r_pc;
  logic [7:0] r_a;
  logic [7:0] r_outr;
  logic       r_need_op;  // opcode latched, its operand byte is being fetched

  logic       w_qend;
  logic       w_cond_end;
  logic       w_bit_end;
  logic       w_busy;
  logic       w_byte_st;
  logic [7:0] w_wbyte;
  logic       w_tx_bit;
  logic       w_is2;
  logic       w_z;
  logic       w_scl;
  logic       w_sda;
  logic [3:0] w_n;
  logic       w_unused;

  assign w_unused   = ^{ena, ui_in, uio_in[7:4], uio_in[2:0]};

  assign w_qend     = (r_qcnt == QLAST);
  assign w_cond_end = w_qend && (r_q == 2'd3);
  assign w_bit_end  = w_cond_end && (r_bit == 4'd8);
  assign w_busy     = (r_state == S_START) || (r_state == S_WBYTE) || (r_state == S_RSTART) ||
                      (r_state == S_RBYTE) || (r_state == S_STOP);
  assign w_byte_st  = (r_state == S_WBYTE) || (r_state == S_RBYTE);
  assign w_is2      = (r_rx == 8'h50) || (r_rx == 8'h60) || (r_rx == 8'h70);
  assign w_z        = (r_a == 8'h00);
  assign w_n        = r_ir[3:0];

  always_comb begin
    w_wbyte = DEV_R;
    case (r_wsel)
      2'd0:    w_wbyte = DEV_W;
      2'd1:    w_wbyte = r_pc;
      default: w_wbyte = DEV_R;
    endcase
  end

  // MSB first; slot 8 releases SDA so the device can ACK.
  assign w_tx_bit = r_bit[3] ? 1'b1 : w_wbyte[~r_bit[2:0]];

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    w_scl  = 1'b1;
    w_sda  = 1'b1;
    case (r_state)
      S_IDLE: begin
        w_next = S_START;
      end
      S_START, S_RSTART: begin
        // (1,1) (1,1) (1,0) (0,0): SDA falls while SCL high, then SCL drops.
        w_scl = (r_q != 2'd3);
        w_sda = ~r_q[1];
        if (w_cond_end) w_next = S_WBYTE;
      end
      S_WBYTE: begin
        w_scl = r_q[0] ^ r_q[1];
        w_sda = w_tx_bit;
        if (w_bit_end) begin
          case (r_wsel)
            2'd0:    w_next = S_WBYTE;
            2'd1:    w_next = S_RSTART;
            default: w_next = S_RBYTE;
          endcase
        end
      end
      S_RBYTE: begin
        // SDA released for all data bits and for the final NACK.
        w_scl = r_q[0] ^ r_q[1];
        w_sda = 1'b1;
        if (w_bit_end) w_next = S_STOP;
      end
      S_STOP: begin
        // (0,0) (1,0) (1,1) (1,1): SDA rises while SCL high.
        w_scl = (r_q != 2'd0);
        w_sda = r_q[1];
        if (w_cond_end) begin
          if (!r_need_op && w_is2) w_next = S_START;
          else                     w_next = S_EXEC;
        end
      end
      S_EXEC: begin
        w_next = (r_ir == 8'hFF) ? S_HALT : S_START;
      end
      S_HALT: begin
        w_next = S_HALT;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_qcnt    <= 8'h00;
      r_q       <= 2'd0;
      r_bit     <= 4'd0;
      r_wsel    <= 2'd0;
      r_rx      <= 8'h00;
      r_ir      <= 8'h00;
      r_opnd    <= 8'h00;
      r_pc      <= 8'h00;
      r_a       <= 8'h00;
      r_outr    <= 8'h00;
      r_need_op <= 1'b0;
    end else begin
      // Quarter/bit timing; every phase ends with both counters back at zero.
      if (w_busy) begin
        if (w_qend) begin
          r_qcnt <= 8'h00;
          r_q    <= r_q + 2'd1;
          if (w_byte_st && r_q == 2'd3) begin
            r_bit <= (r_bit == 4'd8) ? 4'd0 : r_bit + 4'd1;
          end
        end else begin
          r_qcnt <= r_qcnt + 8'h01;
        end
      end

      if (r_state == S_START) begin
        r_wsel <= 2'd0;
      end else if (r_state == S_WBYTE && w_bit_end) begin
        r_wsel <= r_wsel + 2'd1;
      end

      // Sample at the end of Q2, the last cycle of SCL high.
      if (r_state == S_RBYTE && w_qend && r_q == 2'd2 && !r_bit[3]) begin
        r_rx <= {r_rx[6:0], uio_in[3]};
      end

      if (r_state == S_STOP && w_cond_end) begin
        r_pc <= r_pc + 8'h01;
        if (r_need_op) begin
          r_opnd    <= r_rx;
          r_need_op <= 1'b0;
        end else begin
          r_ir      <= r_rx;
          r_need_op <= w_is2;
        end
      end

      if (r_state == S_EXEC) begin
        case (r_ir[7:4])
          4'h0: r_a <= {4'h0, w_n};
          4'h1: r_a <= r_a + {4'h0, w_n};
          4'h2: r_a <= r_a - {4'h0, w_n};
          4'h3: r_a <= {w_n, r_a[3:0]};
          4'h4: begin
            if (r_ir == 8'h40)      r_outr <= r_a;
            else if (r_ir == 8'h41) r_a    <= r_a ^ r_outr;
          end
          4'h5: if (r_ir == 8'h50)         r_pc <= r_opnd;
          4'h6: if (r_ir == 8'h60 && !w_z) r_pc <= r_opnd;
          4'h7: if (r_ir == 8'h70 && w_z)  r_pc <= r_opnd;
          default: ;
        endcase
      end
    end
  end

  assign uo_out  = r_outr;
  assign uio_out = {3'b000, (r_state == S_HALT), w_sda, w_scl, 2'b00};
  assign uio_oe  = 8'b0001_1100;

endmodule

// File: tb/tb_obriensp_be8.sv
// Bench for obriensp_be8: 24C02-style EEPROM model on the I2C pins plus directed programs.
// Latency: n/a. Backpressure: n/a.
// Programs are listed in a vector table; reset, fetch waveform and mid-fetch reset are hand sequences.
module tb_obriensp_be8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  wire  [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  logic       s_sda = 1'b1;            // EEPROM-side SDA drive, 1 = released
  wire        scl_o  = uio_out[2];
  wire        sda_o  = uio_out[3];
  wire        halted = uio_out[4];
  assign uio_in = {4'b0000, sda_o & s_sda, scl_o, 2'b00};

  obriensp_be8 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [256];

  // EEPROM model state (written only by the model process)
  int         phase;        // 0 dev addr, 1 word addr, 2 reading, 3 idle
  int         bitcnt;
  logic [7:0] sh;
  logic [7:0] ptr;
  logic [7:0] rdat;
  logic       nack;
  int         starts, stops, scl_rises, glitches;
  logic       prev_scl, prev_sda;
  logic [7:0] prev_uo;
  logic [7:0] wlog [$];
  logic [7:0] outs [$];

  always @(negedge clk) begin
    if (rst_n) begin
      phase = 3; bitcnt = 0; s_sda = 1'b1; nack = 1'b0;
      starts = 0; stops = 0; scl_rises = 0; glitches = 0;
      prev_scl = 1'b1; prev_sda = 1'b1; prev_uo = 8'h00;
      sh = 8'h00; ptr = 8'h00; rdat = 8'h00;
      wlog.delete(); outs.delete();
    end else begin
      if (scl_o != prev_scl && sda_o != prev_sda) glitches++;
      if (prev_scl && scl_o && prev_sda && !sda_o) begin
        starts++; phase = 0; bitcnt = 0; s_sda = 1'b1;
      end else if (prev_scl && scl_o && !prev_sda && sda_o) begin
        stops++; phase = 3; s_sda = 1'b1;
      end else if (!prev_scl && scl_o) begin
        scl_rises++;
        if (phase <= 1 && bitcnt < 8) begin
          sh = {sh[6:0], sda_o};
          bitcnt++;
          if (bitcnt == 8) wlog.push_back(sh);
        end else if (phase == 2) begin
          bitcnt++;
          if (bitcnt == 9) nack = sda_o;
        end
      end else if (prev_scl && !scl_o) begin
        if (phase <= 1) begin
          if (bitcnt == 8) begin
            s_sda = 1'b0; bitcnt = 9;
          end else if (bitcnt == 9) begin
            s_sda = 1'b1; bitcnt = 0;
            if (phase == 1) begin
              ptr = sh; phase = 3;
            end else if (!sh[0]) begin
              phase = 1;
            end else begin
              phase = 2; rdat = mem[ptr]; s_sda = rdat[7];
            end
          end
        end else if (phase == 2) begin
          if (bitcnt >= 1 && bitcnt <= 7) s_sda = rdat[7 - bitcnt];
          else                            s_sda = 1'b1;
        end
      end
      if (uo_out != prev_uo) outs.push_back(uo_out);
      prev_scl = scl_o; prev_sda = sda_o; prev_uo = uo_out;
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_mem();
    for (int a = 0; a < 256; a++) mem[a] = 8'h00;
  endtask

  task automatic do_reset();
    rst_n = 1'b1;
    repeat (5) tick();
  endtask

  typedef struct {
    string      name;
    logic [7:0] prog [16];
    int         len;
    int         n_out;
    logic [7:0] exp_outs [4];
    logic [7:0] final_out;
  } vec_t;

  vec_t tv [4];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1; ena = 1'b1; ui_in = 8'h5A;
    clear_mem();

    // LDI 5, ADDI 3, OUT, HLT
    tv[0].name = "arith";
    tv[0].prog = '{8'h05, 8'h13, 8'h40, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00,
                   8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    tv[0].len = 4; tv[0].n_out = 1; tv[0].final_out = 8'h08;
    tv[0].exp_outs = '{8'h08, 8'h00, 8'h00, 8'h00};
    // LDI F, OUT(0F), LDH F -> FF, ADDI 1 wraps -> 00, OUT, HLT
    tv[1].name = "wrap_ldh";
    tv[1].prog = '{8'h0F, 8'h40, 8'h3F, 8'h11, 8'h40, 8'hFF, 8'h00, 8'h00,
                   8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    tv[1].len = 6; tv[1].n_out = 2; tv[1].final_out = 8'h00;
    tv[1].exp_outs = '{8'h0F, 8'h00, 8'h00, 8'h00};
    // countdown loop 3,2,1 via JNZ
    tv[2].name = "loop";
    tv[2].prog = '{8'h03, 8'h40, 8'h21, 8'h60, 8'h01, 8'hFF, 8'h00, 8'h00,
                   8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    tv[2].len = 6; tv[2].n_out = 3; tv[2].final_out = 8'h01;
    tv[2].exp_outs = '{8'h03, 8'h02, 8'h01, 8'h00};
    // LDI0, JZ 5 (taken), skip, LDI9 OUT, JMP 11, skip, LDI6, XOR->0F, OUT, NOP(9A), HLT
    tv[3].name = "jump_xor";
    tv[3].prog = '{8'h00, 8'h70, 8'h05, 8'h0E, 8'h40, 8'h09, 8'h40, 8'h50,
                   8'h0B, 8'h01, 8'h40, 8'h06, 8'h41, 8'h40, 8'h9A, 8'hFF};
    tv[3].len = 16; tv[3].n_out = 2; tv[3].final_out = 8'h0F;
    tv[3].exp_outs = '{8'h09, 8'h0F, 8'h00, 8'h00};

    // ---- reset state ----
    do_reset();
    check("rst_uo_out", {8'h00, uo_out}, 16'h0000);
    check("rst_scl", {15'h0, scl_o}, 16'h0001);
    check("rst_sda", {15'h0, sda_o}, 16'h0001);
    check("rst_halted", {15'h0, halted}, 16'h0000);
    check("rst_uio_oe", {8'h00, uio_oe}, 16'h001C);
    check("rst_uio_out_other", {8'h00, uio_out & 8'hE3}, 16'h0000);

    // ---- first fetch waveform with all-zero EEPROM ----
    rst_n = 1'b0;
    begin
      int cyc = 0;
      while (stops < 1 && cyc < 1000) begin tick(); cyc++; end
      check("wave_timeout", {15'h0, (cyc >= 1000)}, 16'h0000);
    end
    check("wave_nbytes", 16'(wlog.size()), 16'd3);
    if (wlog.size() >= 3) begin
      check("wave_dev_w", {8'h00, wlog[0]}, 16'h00A0);
      check("wave_word_addr", {8'h00, wlog[1]}, 16'h0000);
      check("wave_dev_r", {8'h00, wlog[2]}, 16'h00A1);
    end
    check("wave_nack", {15'h0, nack}, 16'h0001);
    check("wave_starts", 16'(starts), 16'd2);
    check("wave_glitch", 16'(glitches), 16'd0);
    begin
      int cyc = 0;
      while (wlog.size() < 5 && cyc < 1000) begin tick(); cyc++; end
      if (wlog.size() >= 5) check("wave_pc_inc", {8'h00, wlog[4]}, 16'h0001);
      else                  check("wave_pc_inc_timeout", 16'(wlog.size()), 16'd5);
    end

    // ---- program table ----
    for (int t = 0; t < 4; t++) begin
      do_reset();
      check({tv[t].name, "_rst_halted"}, {15'h0, halted}, 16'h0000);
      clear_mem();
      for (int a = 0; a < tv[t].len; a++) mem[a] = tv[t].prog[a];
      rst_n = 1'b0;
      begin
        int cyc = 0;
        while (!halted && cyc < 6000) begin tick(); cyc++; end
        check({tv[t].name, "_halted"}, {15'h0, halted}, 16'h0001);
      end
      check({tv[t].name, "_final_out"}, {8'h00, uo_out}, {8'h00, tv[t].final_out});
      check({tv[t].name, "_n_outs"}, 16'(outs.size()), 16'(tv[t].n_out));
      for (int k = 0; k < tv[t].n_out; k++) begin
        logic [15:0] got;
        got = (k < outs.size()) ? {8'h00, outs[k]} : 16'hDEAD;
        check({tv[t].name, "_out_seq"}, got, {8'h00, tv[t].exp_outs[k]});
      end
      check({tv[t].name, "_glitch"}, 16'(glitches), 16'd0);
      begin
        int snap;
        snap = scl_rises;
        repeat (200) tick();
        check({tv[t].name, "_halt_quiet"}, 16'(scl_rises - snap), 16'd0);
      end
      check({tv[t].name, "_halt_scl"}, {15'h0, scl_o}, 16'h0001);
      check({tv[t].name, "_halt_sda"}, {15'h0, sda_o}, 16'h0001);
      check({tv[t].name, "_halt_hold"}, {15'h0, halted}, 16'h0001);
    end

    // ---- reset during the word-address byte of the third fetch ----
    do_reset();
    clear_mem();
    for (int a = 0; a < tv[2].len; a++) mem[a] = tv[2].prog[a];
    rst_n = 1'b0;
    begin
      int cyc = 0;
      while (!(starts == 5 && phase == 1 && bitcnt >= 2) && cyc < 2000) begin tick(); cyc++; end
      check("midrst_reach", {15'h0, (cyc >= 2000)}, 16'h0000);
      check("midrst_in_addr", {15'h0, scl_o & sda_o & (phase == 1)}, 16'h0000);
    end
    rst_n = 1'b1;
    tick();
    check("midrst_scl", {15'h0, scl_o}, 16'h0001);
    check("midrst_sda", {15'h0, sda_o}, 16'h0001);
    check("midrst_uo_out", {8'h00, uo_out}, 16'h0000);
    repeat (3) tick();
    rst_n = 1'b0;
    begin
      int cyc = 0;
      while (wlog.size() < 2 && cyc < 1000) begin tick(); cyc++; end
      if (wlog.size() >= 2) begin
        check("midrst_dev_w", {8'h00, wlog[0]}, 16'h00A0);
        check("midrst_restart_pc", {8'h00, wlog[1]}, 16'h0000);
      end else begin
        check("midrst_restart_timeout", 16'(wlog.size()), 16'd2);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
